// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the five-stage MIPS pipeline.
//
// Owns the PC and drives a req / addr_ok / data_ok handshake to the
// instruction SRAM. Each returned word is buffered in ibuf until ID accepts
// it. ID then receives {ce, pc} and the PC-aligned instruction together, as
// registered values.
//
// Optional feature: define IF_ADDR_CHECK_EN to flag misaligned fetch
// addresses. A misaligned fetch issues no SRAM request, hands off a zero
// word and raises if_excp. With the macro undefined, the SRAM address is
// forced word-aligned and if_excp is tied to 0.
//
// Ports:
//   clk           in   clock, rising edge
//   resetn        in   asynchronous active-low reset
//   stall[5:0]    in   pipeline stall vector (bit 1 = IF stop, bit 2 = ID stop)
//   br_bus[32:0]  in   {br_e, br_addr} from ID
//   inst_req      out  SRAM request valid
//   inst_addr     out  SRAM word address
//   inst_addr_ok  in   request accepted this cycle
//   inst_data_ok  in   inst_rdata valid this cycle
//   inst_rdata    in   fetched word
//   if_to_id_bus  out  {ce, pc}, registered
//   if_inst       out  instruction for pc, registered
//   if_stallreq   out  current fetch not yet complete
//   if_excp       out  fetch address error, registered
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] if_inst,
  output logic        if_stallreq,
  output logic        if_excp
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] ibuf;
  logic        pend_br;
  logic [31:0] pend_addr;
  logic        started;
  logic        misaligned;
  logic        handoff;
  logic        bubble;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic        unused_stall;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // Only the IF and ID stop bits matter to this stage.
  assign unused_stall = ^{stall[5:3], stall[0]};

`ifdef IF_ADDR_CHECK_EN
  assign misaligned = |pc_r[1:0];
  assign inst_addr  = pc_r;
`else
  assign misaligned = 1'b0;
  assign inst_addr  = {pc_r[31:2], 2'b00};
`endif

  // started keeps the request low until the first edge after reset release.
  assign inst_req    = started && (state == S_REQ) && !misaligned;
  assign if_stallreq = (state != S_DONE);
  assign handoff     = !stall[1] && (state == S_DONE);
  assign bubble      = stall[1] && !stall[2];

  // A branch seen while the delay slot is still in flight takes effect only
  // after that slot has been handed off.
  assign next_pc = pend_br ? pend_addr :
                   br_e    ? br_addr   :
                             pc_r + 32'd4;

  // ---- stage boundary: SRAM handshake and IF->ID output registers ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_REQ;
      started      <= 1'b0;
      pc_r         <= RESET_PC;
      ibuf         <= 32'd0;
      pend_br      <= 1'b0;
      if_to_id_bus <= 33'd0;
      if_inst      <= 32'd0;
    end else begin
      started <= 1'b1;
      case (state)
        S_REQ: begin
          // data_ok without addr_ok is a stale return from before a reset.
          if (started) begin
            if (misaligned) begin
              state <= S_DONE;
              ibuf  <= 32'd0;
            end else if (inst_addr_ok && inst_data_ok) begin
              state <= S_DONE;
              ibuf  <= inst_rdata;
            end else if (inst_addr_ok) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            state <= S_DONE;
            ibuf  <= inst_rdata;
          end
        end
        S_DONE: begin
          if (handoff) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      if (handoff) begin
        if_to_id_bus <= {1'b1, pc_r};
        if_inst      <= ibuf;
        pc_r         <= next_pc;
      end else if (bubble) begin
        if_to_id_bus <= 33'd0;
        if_inst      <= 32'd0;
      end

      // Holding br_e high across ID stalls re-latches nothing new.
      if (handoff) begin
        pend_br <= 1'b0;
      end else if (br_e && !pend_br) begin
        pend_br <= 1'b1;
      end
    end
  end

  // Branch target is plain data and needs no reset; pend_br qualifies it.
  always_ff @(posedge clk) begin
    if (br_e && !pend_br) begin
      pend_addr <= br_addr;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  logic addr_err;
  logic excp_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_err <= 1'b0;
      excp_r   <= 1'b0;
    end else begin
      if (state == S_REQ && started) begin
        if (misaligned) begin
          addr_err <= 1'b1;
        end else if (inst_addr_ok) begin
          addr_err <= 1'b0;
        end
      end
      if (handoff) begin
        excp_r <= addr_err;
      end else if (bubble) begin
        excp_r <= 1'b0;
      end
    end
  end

  assign if_excp = excp_r;
`else
  assign if_excp = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scoreboard bench for if_fetch_unit.
// The stimulus process drives the SRAM handshake and stall/branch inputs,
// pushing each expected {ce, pc, inst, excp} handoff into a queue; a monitor
// pops and compares whenever a new handoff appears on the IF->ID outputs.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        if_stallreq;
  logic        if_excp;

  int errors = 0;
  int checks = 0;

  logic [65:0] exp_q[$];
  logic [65:0] cur;
  logic [65:0] prev = '0;
  logic [65:0] expv;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'hbfc00000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (stall),
    .br_bus       (br_bus),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_to_id_bus (if_to_id_bus),
    .if_inst      (if_inst),
    .if_stallreq  (if_stallreq),
    .if_excp      (if_excp)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h0f0f0f0f;
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cyc(input logic aok, input logic dok, input logic [31:0] rd);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string name, input logic req, input logic [31:0] addr);
    chk({name, "_req"}, inst_req, req);
    if (req) chk({name, "_addr"}, inst_addr, addr);
  endtask

  // Monitor: a fresh handoff is any cycle where ce=1 and the outputs changed.
  always @(negedge clk) begin
    cur = {if_to_id_bus, if_inst, if_excp};
    if (cur[65] && cur !== prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handoff_unexpected: got %h expected none", cur);
      end else begin
        expv = exp_q.pop_front();
        chk("handoff", cur, expv);
      end
    end
    prev = cur;
  end

  initial begin
    resetn = 1'b0; stall = 6'd0; br_bus = 33'd0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", if_to_id_bus, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_excp", if_excp, 0);
    chk("rst_stallreq", if_stallreq, 1);
    resetn = 1'b1;
    cyc(0, 0, 0);
    chk_req("first", 1, 32'hbfc00000);

    // Back-to-back zero-wait fetches.
    exp_q.push_back({1'b1, 32'hbfc00000, word(32'hbfc00000), 1'b0});
    cyc(1, 1, word(32'hbfc00000));
    chk("done_req", inst_req, 0);
    chk("done_stallreq", if_stallreq, 0);
    cyc(0, 0, 0);
    chk_req("seq1", 1, 32'hbfc00004);
    exp_q.push_back({1'b1, 32'hbfc00004, word(32'hbfc00004), 1'b0});
    cyc(1, 1, word(32'hbfc00004));
    cyc(0, 0, 0);
    chk_req("seq2", 1, 32'hbfc00008);

    // addr_ok delayed 3 cycles with IF stopped: address held, bubbles to ID.
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk_req("hold", 1, 32'hbfc00008);
      chk("hold_stallreq", if_stallreq, 1);
      chk("bubble_bus", if_to_id_bus, 0);
    end
    cyc(1, 0, 0);
    chk("wait_req", inst_req, 0);
    chk("wait_stallreq", if_stallreq, 1);

    // Branch pulse while the delay slot is in WAIT.
    br_bus = {1'b1, 32'hbfc00100};
    cyc(0, 0, 0);
    br_bus = 33'd0;
    stall = 6'd0;
    exp_q.push_back({1'b1, 32'hbfc00008, word(32'hbfc00008), 1'b0});
    cyc(0, 1, word(32'hbfc00008));
    chk("slot_stallreq", if_stallreq, 0);
    cyc(0, 0, 0);
    chk_req("br_target", 1, 32'hbfc00100);

    // Word held in DONE across a full IF+ID stall.
    cyc(1, 1, word(32'hbfc00100));
    stall = 6'b000111;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      chk("held_req", inst_req, 0);
      chk("held_bus", if_to_id_bus, {1'b1, 32'hbfc00008});
      chk("held_inst", if_inst, word(32'hbfc00008));
    end
    stall = 6'd0;
    exp_q.push_back({1'b1, 32'hbfc00100, word(32'hbfc00100), 1'b0});
    cyc(0, 0, 0);
    chk_req("after_hold", 1, 32'hbfc00104);

    // Reset during WAIT, stale data_ok one cycle after release.
    cyc(1, 0, 0);
    chk("wait2_req", inst_req, 0);
    resetn = 1'b0;
    #2;
    chk("async_rst_bus", if_to_id_bus, 0);
    chk("async_rst_stallreq", if_stallreq, 1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(0, 1, 32'hdeadbeef);
    chk_req("restart", 1, 32'hbfc00000);
    chk("restart_stallreq", if_stallreq, 1);
    exp_q.push_back({1'b1, 32'hbfc00000, word(32'hbfc00000), 1'b0});
    cyc(1, 1, word(32'hbfc00000));
    cyc(0, 0, 0);
    chk_req("restart_next", 1, 32'hbfc00004);

    // Branch to a misaligned target.
    br_bus = {1'b1, 32'hbfc00102};
    exp_q.push_back({1'b1, 32'hbfc00004, word(32'hbfc00004), 1'b0});
    cyc(1, 1, word(32'hbfc00004));
    br_bus = 33'd0;
    cyc(0, 0, 0);
`ifdef IF_ADDR_CHECK_EN
    chk("misalign_req", inst_req, 0);
    exp_q.push_back({1'b1, 32'hbfc00102, 32'd0, 1'b1});
    cyc(0, 0, 0);
    chk("misalign_req2", inst_req, 0);
    chk("misalign_stallreq", if_stallreq, 0);
    cyc(0, 0, 0);
    chk("misalign_excp", if_excp, 1);
`else
    chk_req("align", 1, 32'hbfc00100);
    exp_q.push_back({1'b1, 32'hbfc00102, word(32'hbfc00100), 1'b0});
    cyc(1, 1, word(32'hbfc00100));
    cyc(0, 0, 0);
    chk_req("align_next", 1, 32'hbfc00104);

    // PC wrap at the top of the address space.
    br_bus = {1'b1, 32'hfffffffc};
    exp_q.push_back({1'b1, 32'hbfc00106, word(32'hbfc00104), 1'b0});
    cyc(1, 1, word(32'hbfc00104));
    br_bus = 33'd0;
    cyc(0, 0, 0);
    chk_req("top", 1, 32'hfffffffc);
    exp_q.push_back({1'b1, 32'hfffffffc, word(32'hfffffffc), 1'b0});
    cyc(1, 1, word(32'hfffffffc));
    cyc(0, 0, 0);
    chk_req("wrap", 1, 32'h00000000);
    chk("wrap_excp", if_excp, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline: the producing end of the IF→ID bus and the consuming end of the ID branch bus. Owns the PC. Drives a request/address-ok/data-ok handshake to the instruction SRAM and buffers each returned word until ID accepts it. Delivers `{ce, pc}` together with a registered, PC-aligned instruction word, so ID needs no stall-replay instruction latch.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc00000: address of the first fetch after reset.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `stall` in `StallBus` (6): pipeline stall vector. Bit 1 = IF stop, bit 2 = ID stop.
- `br_bus` in `BR_WD` (33): `{br_e, br_addr}` from ID.
- `inst_req` out 1: SRAM request valid.
- `inst_addr` out 32: SRAM word address.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: `inst_rdata` valid this cycle.
- `inst_rdata` in 32: fetched word.
- `if_to_id_bus` out `IF_TO_ID_WD` (33): `{ce, pc}`, registered.
- `if_inst` out 32: instruction for `pc`, registered.
- `if_stallreq` out 1: current fetch not yet complete.
- `if_excp` out 1: fetch address error, registered; tied 0 unless the macro below is defined.

## Operation
- **States**
  - REQ: `inst_req`=1, `inst_addr`=`pc_r`.
  - WAIT: `inst_req`=0, waiting for data.
  - DONE: word held in `ibuf`.
- **REQ transitions**
  - `inst_addr_ok` & `inst_data_ok` in the same cycle → capture `inst_rdata`, go to DONE.
  - `inst_addr_ok` only → WAIT.
  - `inst_data_ok` without `inst_addr_ok` is ignored. Such a return is stale data from before a reset.
- **WAIT transition:** on `inst_data_ok`, capture `inst_rdata` into `ibuf`, go to DONE.
- **Stall request:** `if_stallreq` = (state != DONE).
- **Output register update**, priority order:
  - Handoff, when `stall[1]`=NoStop and state=DONE: `if_to_id_bus`<={1,`pc_r`}, `if_inst`<=`ibuf`, `pc_r`<=`next_pc`, clear `pend_br`, state<=REQ.
  - Bubble, when `stall[1]`=Stop and `stall[2]`=NoStop: `if_to_id_bus`<=0, `if_inst`<=0.
  - Otherwise hold.
- **Branch capture and next-PC selection**
  - While `br_e`=1 and `pend_br`=0, latch `pend_br`<=1 and `pend_addr`<=`br_addr`.
  - `next_pc` = `pend_br` ? `pend_addr` : `br_e` ? `br_addr` : `pc_r`+4.
  - The redirect therefore applies after the delay slot (the word in flight) is handed off.
  - `br_e` held high across ID stalls is idempotent.
- **Arithmetic:** `pc_r`+4 is 32-bit modulo; 32'hfffffffc wraps to 0.
- **Reset mid-transaction:** state returns to REQ and the outstanding request is abandoned; a late `inst_data_ok` in REQ is ignored.

## Timing
- **Reset values:** `pc_r`=`RESET_PC`, state=REQ, `pend_br`=0, `ibuf`=0.
  - Outputs: `if_to_id_bus`=0, `if_inst`=0, `if_excp`=0, `if_stallreq`=1.
  - Output `inst_req`=1 and `inst_addr`=`RESET_PC` from the first edge after `resetn` deasserts.
- **Request holding:** `inst_addr` stays stable while `inst_req`=1 and `inst_addr_ok`=0.
- **Latency:** with `addr_ok` and `data_ok` both in the request cycle, the word appears on `if_inst` 2 edges after the request is first driven.
  - Throughput: one instruction per 2 cycles.
  - Each extra SRAM wait cycle adds one cycle.
- **Held word:** while DONE and `stall[1]`=Stop, `ibuf` is held and no new request is issued.

## Configuration
- **`IF_ADDR_CHECK_EN` defined:** in REQ, if `pc_r[1:0]`≠0:
  - suppress `inst_req`;
  - go directly to DONE with `ibuf`=0;
  - at handoff, set `if_excp`<=1 with that PC; `if_excp` clears on the next handoff or bubble.
- **Undefined:** `inst_addr`={`pc_r[31:2]`,2'b00} and `if_excp` is constant 0.

## Test plan
- Reset release with `addr_ok`=`data_ok`=1 every request cycle and `stall`=0 → `inst_addr` 0xbfc00000, 0xbfc00004, 0xbfc00008 on alternate cycles; `if_to_id_bus` = {1,0xbfc00000} with the matching `if_inst`.
- `addr_ok` delayed 3 cycles → `inst_addr` stable for 4 cycles, `if_stallreq`=1 throughout, and ID receives bubbles (`if_to_id_bus`=0) when `stall`=6'b000011.
- `br_bus`={1,0xbfc00100} pulsed while 0xbfc00008 (delay slot) is in WAIT → 0xbfc00008 handed off, next request 0xbfc00100.
- `stall`=6'b000111 for 5 cycles while in DONE → `inst_req`=0 and outputs held; on release, the buffered word is delivered with the correct PC.
- `resetn` low during WAIT, with `inst_data_ok` arriving 1 cycle after release → word ignored; the fetch restarts at 0xbfc00000.
- With `IF_ADDR_CHECK_EN`, branch to 0xbfc00102 → no `inst_req`; handoff of `{1,0xbfc00102}` with `if_inst`=0 and `if_excp`=1.
